// File: rtl/pwm_shadow_reg_bank_pkg.sv
// Shared types for the PWM shadow/active compare-register bank.
// Carries the on/off and update-mode enums plus the event qualifier used by the divider.
package pwm_shadow_reg_bank_pkg;

  localparam int unsigned PWMCOUNT_WIDTH = 16;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [1:0] {
    UPD_ZERO  = 2'd0,
    UPD_PEAK  = 2'd1,
    UPD_BOTH  = 2'd2,
    UPD_IMMED = 2'd3
  } _upd_mode;

  // Simultaneous zero/peak pulses in UPD_BOTH collapse into a single event.
  function automatic logic qualify_event(_upd_mode mode, logic evt_zero, logic evt_peak);
    logic q;
    q = 1'b0;
    case (mode)
      UPD_ZERO:  q = evt_zero;
      UPD_PEAK:  q = evt_peak;
      UPD_BOTH:  q = evt_zero | evt_peak;
      UPD_IMMED: q = 1'b1;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/pwm_shadow_reg_bank_if.sv
// Shadow-write bus from the register file into the PWM compare bank.
// The register file drives it through master; the bank samples it through slave.
interface pwm_shadow_reg_bank_if
  import pwm_shadow_reg_bank_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = PWMCOUNT_WIDTH
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output wr_en,
    output wr_ch,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_ch,
    input wr_data
  );

endinterface

// File: rtl/pwm_shadow_reg_bank_event_divider.sv
// Commit-event decimator: qualifies carrier events by mode and fires on every (evt_div+1)-th one.
// A mode change restarts the count; PWM_OFF holds the count at zero.
module pwm_event_divider
  import pwm_shadow_reg_bank_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  _pwm_onoff        pwm_onoff,
  input  _upd_mode         upd_mode,
  input  logic             evt_zero,
  input  logic             evt_peak,
  input  logic [DIV_W-1:0] evt_div,
  output logic             fire,
  output logic [DIV_W-1:0] cnt
);

  _upd_mode         mode_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             q_evt;
  logic             mode_chg;

  assign q_evt    = qualify_event(upd_mode, evt_zero, evt_peak);
  assign mode_chg = (upd_mode != mode_q);
  assign cnt      = cnt_q;

  // A ratio lowered below the current count lets the counter roll over naturally without firing.
  always_comb begin
    cnt_d = cnt_q;
    fire  = 1'b0;
    if (pwm_onoff == PWM_OFF) begin
      cnt_d = '0;
    end else if (mode_chg) begin
      cnt_d = '0;
    end else if (q_evt) begin
      if (cnt_q == evt_div) begin
        fire  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The mode register tracks its input during reset so leaving reset is not seen as a mode change.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      mode_q <= upd_mode;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= upd_mode;
    end
  end

endmodule

// File: rtl/pwm_shadow_reg_bank.sv
// Multi-channel shadow/active register bank for PWM compare values.
// Shadows are written by the register file; active values update atomically on a commit.
module pwm_shadow_reg_bank
  import pwm_shadow_reg_bank_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = PWMCOUNT_WIDTH,
  parameter int unsigned DIV_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  _pwm_onoff             pwm_onoff,
  input  _upd_mode              upd_mode,
  input  logic                  evt_zero,
  input  logic                  evt_peak,
  input  logic [DIV_W-1:0]      evt_div,
  input  logic                  lock,
  pwm_shadow_reg_bank_if.slave  wr,
  output logic [N_CH*WIDTH-1:0] active_out,
  output logic [N_CH-1:0]       pending,
  output logic                  commit
);

  logic [WIDTH-1:0] shadow_q [N_CH];
  logic [WIDTH-1:0] shadow_d [N_CH];
  logic [WIDTH-1:0] active_q [N_CH];
  logic [WIDTH-1:0] active_d [N_CH];
  logic [N_CH-1:0]  pending_q;
  logic [N_CH-1:0]  pending_d;
  logic             commit_q;
  logic             commit_d;
  logic             fire;
  logic [DIV_W-1:0] evt_cnt;
  logic             wr_ok;

  pwm_event_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .pwm_onoff (pwm_onoff),
    .upd_mode  (upd_mode),
    .evt_zero  (evt_zero),
    .evt_peak  (evt_peak),
    .evt_div   (evt_div),
    .fire      (fire),
    .cnt       (evt_cnt)
  );

  assign wr_ok = wr.wr_en && (32'(wr.wr_ch) < N_CH);

  // Active copies the pre-write shadow; a same-cycle write re-arms its pending bit after the clear.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    commit_d  = (pwm_onoff == PWM_OFF) | (fire & ~lock);
    if (commit_d) begin
      active_d  = shadow_q;
      pending_d = '0;
    end
    if (wr_ok) begin
      shadow_d[wr.wr_ch]  = wr.wr_data;
      pending_d[wr.wr_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      pending_q <= '0;
      commit_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      commit_q  <= commit_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_pack
    assign active_out[k*WIDTH +: WIDTH] = active_q[k];
  end

  assign pending = pending_q;
  assign commit  = commit_q;

endmodule

// File: tb/tb_pwm_shadow_reg_bank.sv
// Self-checking bench for pwm_shadow_reg_bank: directed scenarios then randomized traffic,
// all compared against a cycle-level behavioural model of the bank.
module tb_pwm_shadow_reg_bank;
  import pwm_shadow_reg_bank_pkg::*;

  localparam int unsigned NCH = 8;
  localparam int unsigned W   = 16;

  logic      clk = 1'b0;
  logic      reset;
  _pwm_onoff pwm_onoff;
  _upd_mode  upd_mode;
  logic      evt_zero, evt_peak, lock;
  logic [3:0] evt_div;
  logic [NCH*W-1:0] active_out;
  logic [NCH-1:0]   pending;
  logic             commit;

  logic [6*W-1:0] act6;
  logic [5:0]     pend6;
  logic           com6;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [W-1:0] m_shadow [NCH];
  logic [W-1:0] m_active [NCH];
  logic [NCH-1:0] m_pending;
  logic         m_commit;
  int           m_cnt;
  _upd_mode     m_mode;

  always #5 clk = ~clk;

  pwm_shadow_reg_bank_if #(.N_CH(NCH), .WIDTH(W)) bus0 ();
  pwm_shadow_reg_bank_if #(.N_CH(6),   .WIDTH(W)) bus1 ();

  pwm_shadow_reg_bank #(.N_CH(NCH), .WIDTH(W), .DIV_W(4)) dut (
    .clk(clk), .reset(reset), .pwm_onoff(pwm_onoff), .upd_mode(upd_mode),
    .evt_zero(evt_zero), .evt_peak(evt_peak), .evt_div(evt_div), .lock(lock),
    .wr(bus0.slave), .active_out(active_out), .pending(pending), .commit(commit)
  );

  pwm_shadow_reg_bank #(.N_CH(6), .WIDTH(W), .DIV_W(4)) dut6 (
    .clk(clk), .reset(reset), .pwm_onoff(PWM_ON), .upd_mode(UPD_ZERO),
    .evt_zero(1'b0), .evt_peak(1'b0), .evt_div(4'd0), .lock(1'b0),
    .wr(bus1.slave), .active_out(act6), .pending(pend6), .commit(com6)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] ach(input int k);
    return active_out[k*W +: W];
  endfunction

  function automatic logic [NCH*W-1:0] m_active_packed();
    logic [NCH*W-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*W +: W] = m_active[k];
    return v;
  endfunction

  task automatic model_tick();
    logic qe;
    logic fire;
    logic doc;
    fire = 1'b0;
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        m_shadow[k] = '0;
        m_active[k] = '0;
      end
      m_pending = '0;
      m_commit  = 1'b0;
      m_cnt     = 0;
      m_mode    = upd_mode;
      return;
    end
    case (upd_mode)
      UPD_ZERO: qe = evt_zero;
      UPD_PEAK: qe = evt_peak;
      UPD_BOTH: qe = evt_zero || evt_peak;
      default:  qe = 1'b1;
    endcase
    if (pwm_onoff == PWM_OFF)  m_cnt = 0;
    else if (upd_mode != m_mode) m_cnt = 0;
    else if (qe) begin
      if (m_cnt == int'(evt_div)) begin
        fire  = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % 16;
      end
    end
    m_mode = upd_mode;
    doc = (pwm_onoff == PWM_OFF) || (fire && !lock);
    if (doc) begin
      for (int k = 0; k < NCH; k++) m_active[k] = m_shadow[k];
      m_pending = '0;
    end
    if (bus0.wr_en) begin
      m_shadow[bus0.wr_ch]  = bus0.wr_data;
      m_pending[bus0.wr_ch] = 1'b1;
    end
    m_commit = doc;
  endtask

  // One clock: advance the model with the applied inputs, then compare just after the edge.
  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    check("active",  128'(active_out), 128'(m_active_packed()));
    check("pending", 128'(pending),    128'(m_pending));
    check("commit",  128'(commit),     128'(m_commit));
    check("cnt",     128'(dut.evt_cnt), 128'(m_cnt));
    evt_zero = 1'b0;
    evt_peak = 1'b0;
    bus0.wr_en = 1'b0;
    bus1.wr_en = 1'b0;
  endtask

  task automatic wr0(input int ch, input logic [W-1:0] d);
    bus0.wr_en = 1'b1;
    bus0.wr_ch = 3'(ch);
    bus0.wr_data = d;
  endtask

  initial begin
    reset = 1'b1; pwm_onoff = PWM_ON; upd_mode = UPD_ZERO;
    evt_zero = 1'b0; evt_peak = 1'b0; evt_div = 4'd0; lock = 1'b0;
    bus0.wr_en = 1'b0; bus0.wr_ch = '0; bus0.wr_data = '0;
    bus1.wr_en = 1'b0; bus1.wr_ch = '0; bus1.wr_data = '0;
    step();
    check("rst_active", 128'(active_out), 128'd0);
    reset = 1'b0;

    // 1: single write then commit on evt_zero
    wr0(2, 16'h1234); step();
    check("t1_pend", 128'(pending), 128'h04);
    check("t1_ch2_hold", 128'(ach(2)), 128'h0);
    evt_zero = 1'b1; step();
    check("t1_ch2", 128'(ach(2)), 128'h1234);
    check("t1_commit", 128'(commit), 128'd1);
    step();
    check("t1_commit_low", 128'(commit), 128'd0);

    // 2: UPD_BOTH with ratio 3
    upd_mode = UPD_BOTH; evt_div = 4'd2; wr0(0, 16'h00AA); step();
    evt_zero = 1'b1; step(); check("t2_e1", 128'(commit), 128'd0);
    evt_peak = 1'b1; step(); check("t2_e2", 128'(commit), 128'd0);
    evt_zero = 1'b1; step(); check("t2_e3", 128'(commit), 128'd1);
    check("t2_ch0", 128'(ach(0)), 128'h00AA);
    evt_peak = 1'b1; step(); check("t2_e4", 128'(commit), 128'd0);

    // 3: lock drops a commit, release commits both channels together
    upd_mode = UPD_ZERO; evt_div = 4'd0; lock = 1'b1; step();
    wr0(0, 16'h0011); step();
    wr0(7, 16'h0077); step();
    evt_zero = 1'b1; step();
    check("t3_nocommit", 128'(commit), 128'd0);
    check("t3_pend", 128'(pending), 128'h81);
    lock = 1'b0; step();
    evt_zero = 1'b1; step();
    check("t3_commit", 128'(commit), 128'd1);
    check("t3_ch0", 128'(ach(0)), 128'h0011);
    check("t3_ch7", 128'(ach(7)), 128'h0077);

    // 4: write collides with the firing event
    evt_zero = 1'b1; wr0(3, 16'hBEEF); step();
    check("t4_ch3_old", 128'(ach(3)), 128'h0);
    check("t4_pend", 128'(pending), 128'h08);
    evt_zero = 1'b1; step();
    check("t4_ch3_new", 128'(ach(3)), 128'hBEEF);

    // 5: PWM_OFF transparency ignores lock
    pwm_onoff = PWM_OFF; lock = 1'b1; wr0(5, 16'h0F0F); step();
    check("t5_commit", 128'(commit), 128'd1);
    step();
    check("t5_ch5", 128'(ach(5)), 128'h0F0F);
    check("t5_commit2", 128'(commit), 128'd1);
    pwm_onoff = PWM_ON; lock = 1'b0;

    // 6: reset mid-sequence, then out-of-range write on the 6-channel build
    evt_div = 4'd3; evt_zero = 1'b1; step();
    check("t6_cnt1", 128'(dut.evt_cnt), 128'd1);
    wr0(1, 16'h5555); step();
    check("t6_pend", 128'(pending), 128'h02);
    reset = 1'b1; step();
    check("t6_active", 128'(active_out), 128'd0);
    check("t6_pend0", 128'(pending), 128'd0);
    check("t6_commit0", 128'(commit), 128'd0);
    check("t6_cnt0", 128'(dut.evt_cnt), 128'd0);
    check("t6_pend6_rst", 128'(pend6), 128'd0);
    reset = 1'b0;
    bus1.wr_en = 1'b1; bus1.wr_ch = 3'd6; bus1.wr_data = 16'hDEAD; step();
    check("t6_oob", 128'(pend6), 128'd0);
    bus1.wr_en = 1'b1; bus1.wr_ch = 3'd5; bus1.wr_data = 16'h1111; step();
    check("t6_ch5", 128'(pend6), 128'h20);
    bus1.wr_en = 1'b1; bus1.wr_ch = 3'd6; bus1.wr_data = 16'hDEAD; step();
    check("t6_oob2", 128'(pend6), 128'h20);
    check("t6_act6", 128'(act6), 128'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 31) == 0) upd_mode = _upd_mode'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) evt_div = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) lock = ~lock;
      if ($urandom_range(0, 63) == 0)
        pwm_onoff = ($urandom_range(0, 3) == 0) ? PWM_OFF : PWM_ON;
      evt_zero = ($urandom_range(0, 3) == 0);
      evt_peak = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) wr0($urandom_range(0, NCH - 1), 16'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
